axis2wb_mux: RTL and testbench

Multi-channel, buffered successor to the single-byte AXI-Stream-to-Wishbone bridge used by the emitter SoC. Each of `CHANNELS` AXI-Stream inputs feeds its own `DEPTH`-entry FIFO of `{tlast, tdata}`. The CPU dbus (through the emitter mux) pops entries, reads fill status, and controls flush and interrupt enable per channel over a Wishbone slave port. `o_irq` goes to the CPU so firmware no longer has to poll an unbuffered byte.

---
 rtl/axis2wb_mux.sv | 142 ++++++++++++++
 tb/tb_axis2wb_mux.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis2wb_mux.sv
// axis2wb_mux: per-channel AXI-Stream FIFOs drained by the CPU
// over a Wishbone slave port, with per-channel flush and irq.
module axis2wb_mux #(
  parameter int CHANNELS = 2,
  parameter int DW       = 8,
  parameter int DEPTH    = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [$clog2(CHANNELS):0]  i_wb_adr,
  input  logic [31:0]                i_wb_dat,
  input  logic                       i_wb_we,
  input  logic                       i_wb_stb,
  output logic [31:0]                o_wb_rdt,
  output logic                       o_wb_ack,
  input  logic [CHANNELS*DW-1:0]     i_tdata,
  input  logic [CHANNELS-1:0]        i_tlast,
  input  logic [CHANNELS-1:0]        i_tvalid,
  output logic [CHANNELS-1:0]        o_tready,
  output logic                       o_irq
);

  localparam int AW = $clog2(CHANNELS) + 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);

  logic                          ack_q, ack_d;
  logic [31:0]                   rdt_q, rdt_d;
  logic                          irq_q, irq_d;
  logic [CHANNELS-1:0]           rdy_q, rdy_d;
  logic [CHANNELS-1:0]           en_q, en_d;
  logic [CHANNELS-1:0][NW-1:0]   cnt_q, cnt_d;
  logic [CHANNELS-1:0][PW-1:0]   wp_q, wp_d;
  logic [CHANNELS-1:0][PW-1:0]   rp_q, rp_d;
  logic [CHANNELS-1:0][DW:0]     head;
  logic [CHANNELS-1:0]           push, pop, flush, hit;
  logic [CW-1:0]                 chan;
  logic                          access;
  logic                          unused_dat;

  assign unused_dat = ^i_wb_dat[31:2];

  if (CHANNELS > 1) begin : g_chan
    assign chan = i_wb_adr[AW-1:1];
  end else begin : g_chan1
    assign chan = '0;
  end

  // A strobe seen while ack is high is the tail of the previous access.
  assign access = i_wb_stb & ~ack_q;

  // Per-channel storage; contents are never reset.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_mem
    logic [DW:0] mem [DEPTH];

    // Write the pushed {tlast, tdata} at the write pointer.
    always_ff @(posedge i_clk) begin
      if (push[g]) begin
        mem[wp_q[g]] <= {i_tlast[g], i_tdata[g*DW +: DW]};
      end
    end

    assign head[g] = mem[rp_q[g]];
  end

  // Decode the bus access, update every FIFO and build read data.
  always_comb begin
    ack_d = access;
    rdt_d = '0;
    irq_d = 1'b0;
    rdy_d = rdy_q;
    en_d  = en_q;
    cnt_d = cnt_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    push  = '0;
    pop   = '0;
    flush = '0;
    hit   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      hit[c] = access & (chan == CW'(c));
      if (hit[c] & i_wb_we & i_wb_adr[0]) begin
        en_d[c]  = i_wb_dat[0];
        flush[c] = i_wb_dat[1];
      end
      pop[c]  = hit[c] & ~i_wb_we & ~i_wb_adr[0] & (cnt_q[c] != '0);
      push[c] = i_tvalid[c] & rdy_q[c] & ~flush[c];
      if (hit[c] & ~i_wb_we) begin
        if (i_wb_adr[0]) begin
          rdt_d[NW-1:0] = cnt_q[c];
          rdt_d[16]     = en_q[c];
          rdt_d[17]     = (cnt_q[c] == NW'(DEPTH));
          rdt_d[18]     = (cnt_q[c] == '0);
        end else if (pop[c]) begin
          rdt_d[DW:0]   = head[c];
          rdt_d[DW+1]   = 1'b1;
        end
      end
      if (flush[c]) begin
        cnt_d[c] = '0;
        wp_d[c]  = '0;
        rp_d[c]  = '0;
      end else begin
        cnt_d[c] = cnt_q[c] + NW'(push[c]) - NW'(pop[c]);
        wp_d[c]  = wp_q[c] + PW'(push[c]);
        rp_d[c]  = rp_q[c] + PW'(pop[c]);
      end
      rdy_d[c] = (cnt_d[c] < NW'(DEPTH));
      irq_d    = irq_d | (en_q[c] & (cnt_q[c] != '0));
    end
  end

  // State registers; reset discards any buffered entries.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q <= 1'b0;
      rdt_q <= '0;
      irq_q <= 1'b0;
      rdy_q <= '0;
      en_q  <= '0;
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
    end else begin
      ack_q <= ack_d;
      rdt_q <= rdt_d;
      irq_q <= irq_d;
      rdy_q <= rdy_d;
      en_q  <= en_d;
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_tready = rdy_q;
  assign o_irq    = irq_q;

endmodule

// File: tb/tb_axis2wb_mux.sv
// tb_axis2wb_mux: directed checks of the buffered
// AXI-Stream to Wishbone mux (2 channels, 16 deep).
module tb_axis2wb_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  adr;
  logic [31:0] wdat;
  logic        we;
  logic        stb;
  logic [31:0] rdt;
  logic        ack;
  logic [15:0] tdata;
  logic [1:0]  tlast;
  logic [1:0]  tvalid;
  logic [1:0]  tready;
  logic        irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis2wb_mux #(
    .CHANNELS(2),
    .DW(8),
    .DEPTH(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_wb_adr(adr),
    .i_wb_dat(wdat),
    .i_wb_we(we),
    .i_wb_stb(stb),
    .o_wb_rdt(rdt),
    .o_wb_ack(ack),
    .i_tdata(tdata),
    .i_tlast(tlast),
    .i_tvalid(tvalid),
    .o_tready(tready),
    .o_irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [1:0] a, input logic w,
                    input logic [31:0] d, output logic [31:0] r,
                    output logic k);
    adr  = a;
    we   = w;
    wdat = d;
    stb  = 1'b1;
    step();
    r    = rdt;
    k    = ack;
    stb  = 1'b0;
    we   = 1'b0;
    step();
  endtask

  task automatic rd(input string tag, input logic [1:0] a,
                    input logic [31:0] exp);
    logic [31:0] r;
    logic        k;
    wb(a, 1'b0, 32'h0, r, k);
    chk(tag, r, exp);
  endtask

  task automatic push(input int ch, input logic [7:0] d,
                      input logic l);
    tvalid[ch]       = 1'b1;
    tdata[ch*8 +: 8] = d;
    tlast[ch]        = l;
    step();
    tvalid[ch] = 1'b0;
    tlast[ch]  = 1'b0;
  endtask

  function automatic logic [7:0] bytev(input int i);
    return 8'(i * 7 + 3);
  endfunction

  initial begin
    logic [31:0] r;
    logic        k;
    logic        acc;
    logic [31:0] exp;
    int          sent;
    int          rcv;

    rst    = 1'b1;
    adr    = '0;
    wdat   = '0;
    we     = 1'b0;
    stb    = 1'b0;
    tdata  = '0;
    tlast  = '0;
    tvalid = '0;

    #12;
    chk("rst_tready", 32'(tready), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdt", rdt, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rel_tready_pre", 32'(tready), 32'h0);
    step();
    chk("rel_tready", 32'(tready), 32'h3);

    for (int i = 0; i < 16; i++) push(1, 8'(i), i == 15);
    chk("full_tready", 32'(tready), 32'h1);
    rd("full_stat", 2'd3, 32'h20010);
    for (int i = 0; i < 16; i++)
      rd("fill_pop", 2'd2, (i == 15) ? 32'h30F : (32'h200 | 32'(i)));
    rd("fill_17th", 2'd2, 32'h0);
    chk("fill_tready", 32'(tready), 32'h3);

    sent = 0;
    rcv  = 0;
    for (int cy = 0; cy < 400 && rcv < 40; cy++) begin
      stb        = (cy % 2 == 0);
      adr        = 2'd0;
      we         = 1'b0;
      tvalid[0]  = (sent < 40);
      tdata[7:0] = bytev(sent);
      acc        = tvalid[0] & tready[0];
      exp        = (stb && sent > rcv) ? (32'h200 | 32'(bytev(rcv)))
                                       : 32'h0;
      step();
      if (acc) sent++;
      if (stb) begin
        chk("wrap_rd", rdt, exp);
        if (exp != 0) rcv++;
      end
    end
    stb       = 1'b0;
    tvalid[0] = 1'b0;
    step();
    chk("wrap_sent", 32'(sent), 32'd40);
    chk("wrap_rcv", 32'(rcv), 32'd40);
    rd("wrap_ch1", 2'd3, 32'h40000);
    rd("wrap_ch0", 2'd1, 32'h40000);

    push(0, 8'hA1, 1'b0);
    push(0, 8'hA2, 1'b0);
    push(0, 8'hA3, 1'b0);
    tvalid[0]  = 1'b1;
    tdata[7:0] = 8'hA4;
    adr        = 2'd0;
    stb        = 1'b1;
    step();
    chk("sim_rd", rdt, 32'h2A1);
    stb       = 1'b0;
    tvalid[0] = 1'b0;
    step();
    rd("sim_cnt", 2'd1, 32'h3);
    rd("sim_d2", 2'd0, 32'h2A2);
    rd("sim_d3", 2'd0, 32'h2A3);
    rd("sim_d4", 2'd0, 32'h2A4);
    tvalid[0]  = 1'b1;
    tdata[7:0] = 8'hB5;
    tlast[0]   = 1'b1;
    stb        = 1'b1;
    step();
    chk("sim0_rd", rdt, 32'h0);
    tvalid[0] = 1'b0;
    tlast[0]  = 1'b0;
    stb       = 1'b0;
    step();
    rd("sim0_cnt", 2'd1, 32'h1);
    rd("sim0_d", 2'd0, 32'h3B5);

    push(0, 8'h11, 1'b0);
    wb(2'd0, 1'b1, 32'hFFFF_FFFF, r, k);
    chk("wrdata_ack", 32'(k), 32'h1);
    rd("wrdata_cnt", 2'd1, 32'h1);
    rd("wrdata_d", 2'd0, 32'h211);

    for (int i = 0; i < 7; i++) push(0, 8'(8'h30 + i), 1'b0);
    rd("fl_pre", 2'd1, 32'h7);
    adr        = 2'd1;
    we         = 1'b1;
    wdat       = 32'h3;
    stb        = 1'b1;
    tvalid[0]  = 1'b1;
    tdata[7:0] = 8'hEE;
    step();
    chk("fl_ack", 32'(ack), 32'h1);
    stb       = 1'b0;
    we        = 1'b0;
    tvalid[0] = 1'b0;
    step();
    rd("fl_stat", 2'd1, 32'h50000);
    chk("fl_irq0", 32'(irq), 32'h0);
    push(0, 8'h55, 1'b0);
    chk("fl_irq_push", 32'(irq), 32'h0);
    step();
    step();
    chk("fl_irq_set", 32'(irq), 32'h1);
    rd("fl_data", 2'd0, 32'h255);
    wb(2'd1, 1'b1, 32'h0, r, k);

    wb(2'd3, 1'b1, 32'h1, r, k);
    push(0, 8'h66, 1'b0);
    step();
    step();
    chk("irq_ch0only", 32'(irq), 32'h0);
    push(1, 8'h77, 1'b0);
    push(1, 8'h78, 1'b1);
    step();
    chk("irq_ch1", 32'(irq), 32'h1);
    rd("irq_d1", 2'd2, 32'h277);
    adr = 2'd2;
    stb = 1'b1;
    step();
    chk("irq_d2", rdt, 32'h378);
    chk("irq_at_pop", 32'(irq), 32'h1);
    stb = 1'b0;
    step();
    chk("irq_after_pop", 32'(irq), 32'h0);

    for (int i = 0; i < 4; i++) push(0, 8'(8'hC0 + i), 1'b0);
    rd("prerst_cnt", 2'd1, 32'h5);
    wb(2'd1, 1'b1, 32'h1, r, k);
    chk("prerst_irq", 32'(irq), 32'h1);
    adr = 2'd0;
    stb = 1'b1;
    step();
    chk("prerst_ack", 32'(ack), 32'h1);
    #2;
    rst = 1'b1;
    stb = 1'b0;
    #1;
    chk("mrst_tready", 32'(tready), 32'h0);
    chk("mrst_ack", 32'(ack), 32'h0);
    chk("mrst_irq", 32'(irq), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrel_tready_pre", 32'(tready), 32'h0);
    step();
    chk("mrel_tready", 32'(tready), 32'h3);
    rd("mrel_st0", 2'd1, 32'h40000);
    rd("mrel_st1", 2'd3, 32'h40000);
    rd("mrel_d0", 2'd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
